pc_gen: RTL and testbench

// Parametrised program-counter generator for the pipelined core; successor to the single-cycle PC.

---
 rtl/pc_gen.sv | 158 +++++++++++++++
 tb/tb_pc_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: fetch handshake, prioritised execute-stage redirects,
// circular return-address stack and a FAULT hold on misaligned redirect targets.
//
// state | meaning
// BOOT  | first enabled cycle after reset, no fetch request yet
// RUN   | fetch_pc presented with fetch_valid, redirects applied
// FAULT | misaligned target seen, fetch held until a trap redirect
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter int              IALIGN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_flush,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic            jal_valid,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    output logic            ras_empty
);

    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam logic [PW:0]     RAS_FULL   = (PW+1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t          state, stateNext;
    logic [XLEN-1:0] pc, pcNext;
    logic            flushNext, misNext;

    logic [XLEN-1:0] rasMem [RAS_DEPTH];
    logic [PW-1:0]   rasPtr;
    logic [PW-1:0]   topIdx;
    logic [PW:0]     rasCount;

    logic [XLEN-1:0] target, seqTarget, linkAddr;
    logic            redirValid, isTrap, isJump, misaligned;
    logic            popOk, rasActive, doPush, doPop;

    assign seqTarget = ex_pc + imm;
    assign linkAddr  = ex_pc + XLEN'(4);
    assign topIdx    = rasPtr - PW'(1);
    assign popOk     = jalr_valid && is_ret && (rasCount != '0);

    always_comb begin
        redirValid = 1'b0;
        isTrap     = 1'b0;
        isJump     = 1'b0;
        target     = '0;
        if (trap_valid) begin
            redirValid = 1'b1;
            isTrap     = 1'b1;
            target     = trap_vec;
        end else if (jalr_valid) begin
            redirValid = 1'b1;
            isJump     = 1'b1;
            target     = popOk ? rasMem[topIdx] : (jalr_target & ~XLEN'(1));
        end else if (jal_valid) begin
            redirValid = 1'b1;
            isJump     = 1'b1;
            target     = seqTarget;
        end else if (br_valid && br_taken) begin
            redirValid = 1'b1;
            target     = seqTarget;
        end
    end

    // Trap vectors are trusted; every other target must meet instruction alignment.
    assign misaligned = redirValid && !isTrap && ((target & ALIGN_MASK) != '0);
    assign rasActive  = (state == RUN) && redirValid && isJump && !misaligned;
    assign doPush     = rasActive && is_call;
    assign doPop      = rasActive && popOk;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        flushNext = 1'b0;
        misNext   = 1'b0;
        unique case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (redirValid) begin
                    if (misaligned) begin
                        stateNext = FAULT;
                        misNext   = 1'b1;
                    end else begin
                        pcNext    = target;
                        flushNext = 1'b1;
                    end
                end else if (fetch_ready) begin
                    pcNext = pc + XLEN'(4);
                end
            end
            FAULT: begin
                if (trap_valid) begin
                    stateNext = RUN;
                    pcNext    = trap_vec;
                    flushNext = 1'b1;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_VEC;
            fetch_flush   <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            rasPtr        <= '0;
            rasCount      <= '0;
        end else if (pc_en) begin
            state       <= stateNext;
            pc          <= pcNext;
            fetch_flush <= flushNext;
            misalign    <= misNext;
            if (misNext) misalign_addr <= target;
            // Push+pop replaces the top in place, leaving pointer and count alone.
            if (doPush && !doPop) begin
                rasPtr <= rasPtr + PW'(1);
                if (rasCount != RAS_FULL) rasCount <= rasCount + (PW+1)'(1);
            end else if (doPop && !doPush) begin
                rasPtr   <= rasPtr - PW'(1);
                rasCount <= rasCount - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && pc_en && doPush) begin
            if (doPop) rasMem[topIdx] <= linkAddr;
            else       rasMem[rasPtr] <= linkAddr;
        end
    end

    assign fetch_valid = (state == RUN);
    assign fetch_pc    = pc;
    assign ras_empty   = (rasCount == '0);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a queue-based
// reference model of fetch sequencing, redirect priority and the return-address stack.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b1;
    logic        fetch_ready = 1'b1;
    logic [31:0] ex_pc = '0, imm = '0, jalr_target = '0, trap_vec = '0;
    logic        br_valid = 0, br_taken = 0, jal_valid = 0, jalr_valid = 0;
    logic        is_call = 0, is_ret = 0, trap_valid = 0;

    logic        fetch_valid, fetch_flush, misalign, ras_empty;
    logic [31:0] fetch_pc, misalign_addr;
    logic        d2Valid, d2Flush, d2Mis, d2Empty;
    logic [31:0] d2Pc, d2MisAddr;

    int nChecks = 0;
    int nFail = 0;

    // Reference model state
    int          mState;      // 0 boot, 1 run, 2 fault
    logic [31:0] mPc, mMisAddr;
    logic        mFlush, mMis;
    logic [31:0] rasQ[$];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(4), .IALIGN(32)) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_flush(fetch_flush), .ex_pc(ex_pc), .imm(imm),
        .br_valid(br_valid), .br_taken(br_taken), .jal_valid(jal_valid),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target), .is_call(is_call),
        .is_ret(is_ret), .trap_valid(trap_valid), .trap_vec(trap_vec),
        .misalign(misalign), .misalign_addr(misalign_addr), .ras_empty(ras_empty)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(4), .IALIGN(16)) dut16 (
        .clk(clk), .rst(rst), .pc_en(pc_en),
        .fetch_valid(d2Valid), .fetch_ready(fetch_ready), .fetch_pc(d2Pc),
        .fetch_flush(d2Flush), .ex_pc(ex_pc), .imm(imm),
        .br_valid(br_valid), .br_taken(br_taken), .jal_valid(jal_valid),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target), .is_call(is_call),
        .is_ret(is_ret), .trap_valid(trap_valid), .trap_vec(trap_vec),
        .misalign(d2Mis), .misalign_addr(d2MisAddr), .ras_empty(d2Empty)
    );

    logic [67:0] dutVec;
    assign dutVec = {fetch_valid, fetch_flush, misalign, ras_empty, fetch_pc, misalign_addr};

    function automatic logic [67:0] expVec();
        return {mState == 1, mFlush, mMis, rasQ.size() == 0, mPc, mMisAddr};
    endfunction

    task automatic modelStep();
        logic [31:0] tgt;
        bit redir, jump, trap;
        if (rst) begin
            mState = 0; mPc = RV; mFlush = 0; mMis = 0; mMisAddr = '0;
            rasQ.delete();
        end else if (pc_en) begin
            mFlush = 0;
            mMis   = 0;
            if (mState == 0) begin
                mState = 1;
            end else if (mState == 1) begin
                redir = 1; jump = 0; trap = 0; tgt = '0;
                if (trap_valid) begin
                    tgt = trap_vec; trap = 1;
                end else if (jalr_valid) begin
                    jump = 1;
                    tgt  = (is_ret && rasQ.size() > 0) ? rasQ[$] : {jalr_target[31:1], 1'b0};
                end else if (jal_valid) begin
                    jump = 1; tgt = ex_pc + imm;
                end else if (br_valid && br_taken) begin
                    tgt = ex_pc + imm;
                end else begin
                    redir = 0;
                end
                if (redir && !trap && tgt[1:0] != 2'b00) begin
                    mState = 2; mMis = 1; mMisAddr = tgt;
                end else if (redir) begin
                    mPc = tgt; mFlush = 1;
                    if (jump) begin
                        if (jalr_valid && is_ret && rasQ.size() > 0) void'(rasQ.pop_back());
                        if (is_call) begin
                            rasQ.push_back(ex_pc + 32'd4);
                            if (rasQ.size() > 4) void'(rasQ.pop_front());
                        end
                    end
                end else if (fetch_ready) begin
                    mPc = mPc + 32'd4;
                end
            end else begin
                if (trap_valid) begin
                    mState = 1; mPc = trap_vec; mFlush = 1;
                end
            end
        end
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        br_valid = 0; br_taken = 0; jal_valid = 0; jalr_valid = 0;
        is_call = 0; is_ret = 0; trap_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; pc_en = 1; fetch_ready = 1; clearIn();
        step(); step();
        nChecks++;
        if (fetch_valid !== 1'b0 || fetch_pc !== RV || ras_empty !== 1'b1 || misalign_addr !== 32'h0) begin
            nFail++;
            $display("FAIL reset_state: valid=%b pc=%h empty=%b maddr=%h, required 0 %h 1 0",
                     fetch_valid, fetch_pc, ras_empty, misalign_addr, RV);
        end
        rst = 0;
        step();
        nChecks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100) begin
            nFail++; $display("FAIL boot_first_fetch: valid=%b pc=%h, required 1 00000100", fetch_valid, fetch_pc);
        end
        step();
        nChecks++;
        if (fetch_pc !== 32'h104) begin nFail++; $display("FAIL seq_104: got %h required 00000104", fetch_pc); end
        step();
        nChecks++;
        if (fetch_pc !== 32'h108) begin nFail++; $display("FAIL seq_108: got %h required 00000108", fetch_pc); end
    endtask

    task automatic test_stall();
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nChecks++;
            if (fetch_pc !== 32'h108 || fetch_valid !== 1'b1) begin
                nFail++; $display("FAIL stall_hold[%0d]: pc=%h valid=%b, required 00000108 1", i, fetch_pc, fetch_valid);
            end
        end
        fetch_ready = 1;
        step();
        nChecks++;
        if (fetch_pc !== 32'h10C) begin nFail++; $display("FAIL stall_release: got %h required 0000010c", fetch_pc); end
    endtask

    task automatic test_priority();
        jal_valid = 1; br_valid = 1; br_taken = 1; ex_pc = 32'h200; imm = 32'h40;
        step();
        nChecks++;
        if (fetch_pc !== 32'h240 || fetch_flush !== 1'b1) begin
            nFail++; $display("FAIL jal_over_br: pc=%h flush=%b, required 00000240 1", fetch_pc, fetch_flush);
        end
        clearIn();
        step();
        nChecks++;
        if (fetch_pc !== 32'h244 || fetch_flush !== 1'b0) begin
            nFail++; $display("FAIL flush_one_cycle: pc=%h flush=%b, required 00000244 0", fetch_pc, fetch_flush);
        end
        jal_valid = 1; br_valid = 1; br_taken = 1; trap_valid = 1; trap_vec = 32'h80;
        step();
        nChecks++;
        if (fetch_pc !== 32'h80 || fetch_flush !== 1'b1) begin
            nFail++; $display("FAIL trap_wins: pc=%h flush=%b, required 00000080 1", fetch_pc, fetch_flush);
        end
        clearIn();
        jal_valid = 1; jalr_valid = 1; jalr_target = 32'h401;
        step();
        nChecks++;
        if (fetch_pc !== 32'h400) begin nFail++; $display("FAIL jalr_over_jal: got %h required 00000400", fetch_pc); end
        clearIn();
        br_valid = 1; br_taken = 0;
        step();
        nChecks++;
        if (fetch_pc !== 32'h404 || fetch_flush !== 1'b0) begin
            nFail++; $display("FAIL br_not_taken: pc=%h flush=%b, required 00000404 0", fetch_pc, fetch_flush);
        end
        clearIn();
    endtask

    task automatic test_ras();
        logic [31:0] expRet [5];
        expRet[0] = 32'h54; expRet[1] = 32'h44; expRet[2] = 32'h34; expRet[3] = 32'h24; expRet[4] = 32'h600;
        for (int k = 1; k <= 5; k++) begin
            clearIn();
            jal_valid = 1; is_call = 1; ex_pc = 32'(k * 16); imm = 32'h100;
            step();
        end
        nChecks++;
        if (ras_empty !== 1'b0 || fetch_pc !== 32'h150) begin
            nFail++; $display("FAIL ras_calls: pc=%h empty=%b, required 00000150 0", fetch_pc, ras_empty);
        end
        clearIn();
        jalr_valid = 1; is_ret = 1; jalr_target = 32'h600;
        for (int k = 0; k < 5; k++) begin
            step();
            nChecks++;
            if (fetch_pc !== expRet[k]) begin
                nFail++; $display("FAIL ras_ret[%0d]: got %h required %h", k, fetch_pc, expRet[k]);
            end
        end
        nChecks++;
        if (ras_empty !== 1'b1) begin nFail++; $display("FAIL ras_drained: empty=%b required 1", ras_empty); end
        clearIn();
    endtask

    task automatic test_misalign();
        logic [31:0] held;
        step();
        held = fetch_pc;
        jal_valid = 1; ex_pc = 32'h300; imm = 32'h2;
        step();
        nChecks++;
        if (misalign !== 1'b1 || misalign_addr !== 32'h302 || fetch_valid !== 1'b0 || fetch_pc !== held) begin
            nFail++;
            $display("FAIL misalign_fault: mis=%b addr=%h valid=%b pc=%h, required 1 00000302 0 %h",
                     misalign, misalign_addr, fetch_valid, fetch_pc, held);
        end
        nChecks++;
        if (d2Pc !== 32'h302 || d2Valid !== 1'b1 || d2Mis !== 1'b0) begin
            nFail++; $display("FAIL ialign16_accept: pc=%h valid=%b mis=%b, required 00000302 1 0", d2Pc, d2Valid, d2Mis);
        end
        step();
        nChecks++;
        if (misalign !== 1'b0 || misalign_addr !== 32'h302 || fetch_valid !== 1'b0 || fetch_pc !== held) begin
            nFail++;
            $display("FAIL fault_hold: mis=%b addr=%h valid=%b pc=%h, required 0 00000302 0 %h",
                     misalign, misalign_addr, fetch_valid, fetch_pc, held);
        end
        clearIn();
        trap_valid = 1; trap_vec = 32'h80;
        step();
        nChecks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h80 || fetch_flush !== 1'b1) begin
            nFail++; $display("FAIL fault_trap_exit: valid=%b pc=%h flush=%b, required 1 00000080 1",
                              fetch_valid, fetch_pc, fetch_flush);
        end
        clearIn();
    endtask

    task automatic test_fault_reset();
        jal_valid = 1; is_call = 1; ex_pc = 32'h700; imm = 32'h10;
        step();
        ex_pc = 32'h710;
        step();
        clearIn();
        jal_valid = 1; ex_pc = 32'h300; imm = 32'h2;
        step();
        nChecks++;
        if (dutVec !== expVec() || ras_empty !== 1'b0 || fetch_valid !== 1'b0) begin
            nFail++; $display("FAIL fault_with_ras: got %h required %h", dutVec, expVec());
        end
        clearIn();
        rst = 1;
        step();
        nChecks++;
        if (fetch_valid !== 1'b0 || ras_empty !== 1'b1 || misalign_addr !== 32'h0 || fetch_pc !== RV) begin
            nFail++; $display("FAIL fault_reset: valid=%b empty=%b maddr=%h pc=%h, required 0 1 0 %h",
                              fetch_valid, ras_empty, misalign_addr, fetch_pc, RV);
        end
        rst = 0;
        step();
        nChecks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== RV) begin
            nFail++; $display("FAIL fault_reset_boot: valid=%b pc=%h, required 1 %h", fetch_valid, fetch_pc, RV);
        end
    endtask

    task automatic test_enable();
        logic [31:0] held;
        held = fetch_pc;
        pc_en = 0; jal_valid = 1; ex_pc = 32'h900; imm = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            nChecks++;
            if (fetch_pc !== held || dutVec !== expVec()) begin
                nFail++; $display("FAIL enable_freeze[%0d]: pc=%h required %h", i, fetch_pc, held);
            end
        end
        pc_en = 1; clearIn();
        step();
        nChecks++;
        if (fetch_pc !== held + 32'd4) begin
            nFail++; $display("FAIL enable_resume: got %h required %h", fetch_pc, held + 32'd4);
        end
    endtask

    task automatic test_wrap();
        trap_valid = 1; trap_vec = 32'hFFFF_FFFC;
        step();
        clearIn();
        step();
        nChecks++;
        if (fetch_pc !== 32'h0) begin nFail++; $display("FAIL pc_wrap: got %h required 00000000", fetch_pc); end
        jal_valid = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'h20;
        step();
        nChecks++;
        if (fetch_pc !== 32'h10) begin nFail++; $display("FAIL target_wrap: got %h required 00000010", fetch_pc); end
        clearIn();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            pc_en       = ($urandom_range(0, 7) != 0);
            fetch_ready = $urandom_range(0, 1);
            trap_valid  = ($urandom_range(0, 9) == 0);
            jalr_valid  = ($urandom_range(0, 4) == 0);
            jal_valid   = ($urandom_range(0, 4) == 0);
            br_valid    = ($urandom_range(0, 3) == 0);
            br_taken    = $urandom_range(0, 1);
            is_call     = ($urandom_range(0, 2) == 0);
            is_ret      = ($urandom_range(0, 2) == 0);
            ex_pc       = $urandom & 32'hFFFF_FFFC;
            imm         = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            jalr_target = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            trap_vec    = $urandom & 32'hFFFF_FFFC;
            step();
            nChecks++;
            if (dutVec !== expVec()) begin
                nFail++;
                if (errs < 10) $display("FAIL random[%0d]: got %h required %h", i, dutVec, expVec());
                errs++;
            end
        end
        clearIn();
        pc_en = 1;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_ras();
        test_misalign();
        test_fault_reset();
        test_enable();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
